// File: rtl/sound_cmd_latch.sv
// Sound command latch between the 68000 and the Z80 sound CPU.
// 68k command bytes are queued in a small FIFO. The head byte is presented
// on z80_dout, and one fixed-width NMI is raised per queued command. After
// each NMI the FSM waits for the Z80 to read the latch before it can raise
// the next one.
module sound_cmd_latch #(
    parameter int DEPTH   = 4,
    parameter int NMI_LEN = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sound_latch_cs,
    input  logic       m68k_rw,
    input  logic       m68k_lds_n,
    input  logic [7:0] m68k_din,
    input  logic       z80_latch_cs,
    input  logic       z80_rd_n,
    output logic [7:0] z80_dout,
    output logic       z80_nmi_n,
    output logic       cmd_pending,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [7:0]    NMI_LOAD   = 8'(NMI_LEN - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_WAIT_RD = 2'd2;

    // Strobe edge detection
    logic w_now;
    logic r_now;
    logic w_q_reg;
    logic r_q_reg;
    logic push_req;
    logic pop_req;

    // FIFO state
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          pending_reg;
    logic          overflow_reg;
    logic [7:0]    dout_reg;
    logic          fifo_empty;
    logic          fifo_full;
    logic          do_push;
    logic          do_pop;
    logic          drop;

    // NMI sequencer
    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic [7:0] nmi_cnt_reg;
    logic [7:0] nmi_cnt_next;
    logic       nmi_n_reg;
    logic       nmi_n_next;
    logic       pop_seen_reg;
    logic       pop_seen_next;

    assign w_now    = sound_latch_cs & ~m68k_rw & ~m68k_lds_n;
    assign r_now    = z80_latch_cs & ~z80_rd_n;
    // A 68k write pushes on its leading edge; a Z80 read pops on its
    // trailing edge so the byte stays put for the whole read cycle.
    assign push_req = w_now & ~w_q_reg;
    assign pop_req  = ~r_now & r_q_reg;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == FULL_COUNT);
    assign do_pop     = pop_req & ~fifo_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // still succeeds in that case.
    assign do_push    = push_req & (~fifo_full | do_pop);
    assign drop       = push_req & fifo_full & ~do_pop;

    // Next occupancy from the accepted push/pop pair
    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    // Strobe history, pointers, occupancy and the sticky overflow flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            w_q_reg      <= 1'b0;
            r_q_reg      <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            pending_reg  <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            w_q_reg     <= w_now;
            r_q_reg     <= r_now;
            count_reg   <= count_next;
            pending_reg <= (count_next != '0);
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Command storage; no reset so it maps onto plain RAM
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= m68k_din;
        end
    end

    // Registered head read; holds the last byte while the FIFO is empty
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dout_reg <= 8'h00;
        end else if (!fifo_empty) begin
            dout_reg <= mem[rd_ptr_reg];
        end
    end

    // NMI sequencer next-state: one fixed-width pulse per command, then
    // wait for the Z80 to consume it
    always_comb begin
        state_next    = state_reg;
        nmi_cnt_next  = nmi_cnt_reg;
        nmi_n_next    = nmi_n_reg;
        pop_seen_next = pop_seen_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_next    = ST_ASSERT;
                    nmi_n_next    = 1'b0;
                    nmi_cnt_next  = NMI_LOAD;
                    pop_seen_next = 1'b0;
                end
            end
            ST_ASSERT: begin
                if (nmi_cnt_reg == 8'd0) begin
                    nmi_n_next    = 1'b1;
                    pop_seen_next = 1'b0;
                    // A read that already happened during the pulse counts
                    // as the acknowledge, so skip the wait.
                    state_next    = (pop_seen_reg | do_pop) ? ST_IDLE : ST_WAIT_RD;
                end else begin
                    nmi_cnt_next = nmi_cnt_reg - 8'd1;
                    if (do_pop) begin
                        pop_seen_next = 1'b1;
                    end
                end
            end
            ST_WAIT_RD: begin
                if (do_pop) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next    = ST_IDLE;
                nmi_n_next    = 1'b1;
                pop_seen_next = 1'b0;
            end
        endcase
    end

    // NMI sequencer state registers; reset ends any pulse in progress
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            nmi_cnt_reg  <= 8'd0;
            nmi_n_reg    <= 1'b1;
            pop_seen_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            nmi_cnt_reg  <= nmi_cnt_next;
            nmi_n_reg    <= nmi_n_next;
            pop_seen_reg <= pop_seen_next;
        end
    end

    assign z80_dout    = dout_reg;
    assign z80_nmi_n   = nmi_n_reg;
    assign cmd_pending = pending_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_sound_cmd_latch.sv
// Self-checking bench for sound_cmd_latch. Command bytes are pushed to a
// scoreboard queue when the 68k write is driven and popped/compared when
// the Z80 reads the latch. A monitor measures every NMI pulse.
module tb_sound_cmd_latch;

    localparam int DEPTH   = 4;
    localparam int NMI_LEN = 8;

    logic       clk;
    logic       reset_n;
    logic       sound_latch_cs;
    logic       m68k_rw;
    logic       m68k_lds_n;
    logic [7:0] m68k_din;
    logic       z80_latch_cs;
    logic       z80_rd_n;
    logic [7:0] z80_dout;
    logic       z80_nmi_n;
    logic       cmd_pending;
    logic       overflow;

    int         n_checks;
    int         n_fail;
    int         pulse_count;
    int         low_len;
    logic       abort_pulse;

    logic [7:0] exp_q[$];
    logic [7:0] last_byte;
    logic       exp_ovf;

    sound_cmd_latch #(
        .DEPTH   (DEPTH),
        .NMI_LEN (NMI_LEN)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sound_latch_cs (sound_latch_cs),
        .m68k_rw        (m68k_rw),
        .m68k_lds_n     (m68k_lds_n),
        .m68k_din       (m68k_din),
        .z80_latch_cs   (z80_latch_cs),
        .z80_rd_n       (z80_rd_n),
        .z80_dout       (z80_dout),
        .z80_nmi_n      (z80_nmi_n),
        .cmd_pending    (cmd_pending),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // NMI pulse monitor: every completed pulse must be NMI_LEN cycles long
    initial begin
        low_len     = 0;
        pulse_count = 0;
        forever begin
            @(negedge clk);
            if (z80_nmi_n === 1'b0) begin
                low_len++;
            end else if (low_len > 0) begin
                if (abort_pulse) begin
                    abort_pulse = 1'b0;
                end else begin
                    pulse_count++;
                    check("nmi_width", low_len, NMI_LEN);
                    $display("nmi pulse %0d: %0d cycles", pulse_count, low_len);
                end
                low_len = 0;
            end
        end
    end

    task automatic release_write();
        sound_latch_cs = 1'b0;
        m68k_rw        = 1'b1;
        m68k_lds_n     = 1'b1;
        m68k_din       = 8'h00;
    endtask

    task automatic drive_write(input logic [7:0] d);
        sound_latch_cs = 1'b1;
        m68k_rw        = 1'b0;
        m68k_lds_n     = 1'b0;
        m68k_din       = d;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp_q.delete();
        last_byte = 8'h00;
        exp_ovf   = 1'b0;
        check("rst_dout", z80_dout, 8'h00);
        check("rst_nmi_n", z80_nmi_n, 1'b1);
        check("rst_pending", cmd_pending, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        $display("reset applied");
    endtask

    // 68k write held for 'hold' cycles; the model predicts accept or drop
    task automatic m68k_write(input logic [7:0] d, input int hold);
        @(posedge clk); #1;
        drive_write(d);
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else exp_ovf = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        release_write();
        $display("68k write %02h (queued %0d)", d, exp_q.size());
    endtask

    // Z80 latch read; the byte is compared while the read is active
    task automatic z80_read();
        logic [7:0] exp;
        @(posedge clk); #1;
        z80_latch_cs = 1'b1;
        z80_rd_n     = 1'b0;
        @(posedge clk); #1;
        exp = (exp_q.size() != 0) ? exp_q[0] : last_byte;
        check("rd_data", z80_dout, exp);
        $display("z80 read got %02h expected %02h", z80_dout, exp);
        @(posedge clk); #1;
        z80_latch_cs = 1'b0;
        z80_rd_n     = 1'b1;
        @(posedge clk); #1;
        if (exp_q.size() != 0) last_byte = exp_q.pop_front();
    endtask

    // Single command with latency checks around the push edge E0
    task automatic single_cmd(input logic [7:0] d);
        int p0;
        p0 = pulse_count;
        @(posedge clk); #1;
        drive_write(d);
        exp_q.push_back(d);
        @(posedge clk); #1;
        check("e0_nmi_n", z80_nmi_n, 1'b1);
        check("e0_pending", cmd_pending, 1'b1);
        @(posedge clk); #1;
        check("e1_nmi_n", z80_nmi_n, 1'b0);
        check("e1_dout", z80_dout, d);
        repeat (4) @(posedge clk);
        #1;
        release_write();
        repeat (12) @(posedge clk);
        #1;
        check("single_pulses", pulse_count - p0, 1);
        z80_read();
        check("single_pending", cmd_pending, 1'b0);
        check("single_dout_hold", z80_dout, d);
        $display("single command %02h done", d);
    endtask

    initial begin
        int p0;
        n_checks     = 0;
        n_fail       = 0;
        abort_pulse  = 1'b0;
        reset_n      = 1'b0;
        z80_latch_cs = 1'b0;
        z80_rd_n     = 1'b1;
        last_byte    = 8'h00;
        exp_ovf      = 1'b0;
        release_write();
        repeat (3) @(posedge clk);
        do_reset();

        // Empty pop: nothing changes, no NMI
        p0 = pulse_count;
        z80_read();
        check("empty_pending", cmd_pending, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        check("empty_dout", z80_dout, 8'h00);
        check("empty_nmi_n", z80_nmi_n, 1'b1);
        check("empty_pulses", pulse_count - p0, 0);

        // Single command
        single_cmd(8'h3C);

        // Burst: three commands, one NMI per read
        p0 = pulse_count;
        m68k_write(8'h11, 2);
        m68k_write(8'h22, 2);
        m68k_write(8'h33, 2);
        repeat (15) @(posedge clk);
        #1;
        check("burst_first_pulses", pulse_count - p0, 1);
        for (int i = 0; i < 3; i++) begin
            z80_read();
            if (exp_q.size() != 0) begin
                check("b2b_gap_nmi_n", z80_nmi_n, 1'b1);
                @(posedge clk); #1;
                check("b2b_nmi_n", z80_nmi_n, 1'b0);
                check("b2b_dout", z80_dout, exp_q[0]);
            end
            repeat (15) @(posedge clk);
            #1;
        end
        check("burst_pulses", pulse_count - p0, 3);
        check("burst_pending", cmd_pending, 1'b0);

        // Overflow: fifth write is dropped, flag is sticky
        for (int i = 0; i < 5; i++) m68k_write(8'hA1 + 8'(i), 1);
        @(posedge clk); #1;
        check("ovf_set", overflow, exp_ovf);
        check("ovf_pending", cmd_pending, 1'b1);
        for (int i = 0; i < 4; i++) begin
            repeat (12) @(posedge clk);
            z80_read();
        end
        repeat (12) @(posedge clk);
        #1;
        check("ovf_drained", cmd_pending, 1'b0);
        check("ovf_sticky", overflow, exp_ovf);

        // Full FIFO with a push and pop on the same edge
        do_reset();
        for (int i = 0; i < 4; i++) m68k_write(8'hB1 + 8'(i), 1);
        repeat (12) @(posedge clk);
        #1;
        z80_latch_cs = 1'b1;
        z80_rd_n     = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("full_rd_data", z80_dout, exp_q[0]);
        z80_latch_cs = 1'b0;
        z80_rd_n     = 1'b1;
        drive_write(8'hB5);
        last_byte = exp_q.pop_front();
        exp_q.push_back(8'hB5);
        @(posedge clk); #1;
        check("full_simul_ovf", overflow, 1'b0);
        check("full_simul_pending", cmd_pending, 1'b1);
        @(posedge clk); #1;
        release_write();
        $display("simultaneous pop/push while full");
        m68k_write(8'hB6, 1);
        @(posedge clk); #1;
        check("full_still_full", overflow, exp_ovf);
        for (int i = 0; i < 4; i++) begin
            repeat (12) @(posedge clk);
            z80_read();
        end
        check("full_drained", cmd_pending, 1'b0);

        // Reset on the third cycle of an NMI pulse
        repeat (12) @(posedge clk);
        #1;
        drive_write(8'hC7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        release_write();
        check("mid_nmi_low", z80_nmi_n, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n     = 1'b0;
        abort_pulse = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("mid_rst_nmi_n", z80_nmi_n, 1'b1);
        check("mid_rst_pending", cmd_pending, 1'b0);
        check("mid_rst_dout", z80_dout, 8'h00);
        check("mid_rst_overflow", overflow, 1'b0);
        exp_q.delete();
        last_byte = 8'h00;
        exp_ovf   = 1'b0;
        $display("reset during NMI pulse");
        repeat (3) @(posedge clk);
        single_cmd(8'h5A);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
